linebuf_window_sequencer: RTL and testbench

Control block that sequences the multi-row line-buffer window datapath: row RAM chain plus per-row horizontal shift registers.
- Accepts a raster pixel stream with a valid/ready handshake.
- Tracks column, row and line-fill state.
- Drives the RAM write/read addresses, per-row shift enables and the window-shift enable.
- After the last frame line, self-generates flush lines so the bottom rows of the image leave the window.

---
 rtl/linebuf_window_sequencer_if.sv | 33 +++
 rtl/linebuf_window_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_linebuf_window_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/linebuf_window_sequencer_if.sv
// Pixel-stream handshake plus the window-datapath control bus of the line-buffer sequencer.
interface linebuf_window_sequencer_if #(
  parameter int NUM_ROWS = 6,
  parameter int ADR_W    = 10
);
  logic                pix_valid;
  logic                pix_sof;
  logic                pix_ready;
  logic                shift_en;
  logic [NUM_ROWS-1:0] row_shift_en;
  logic [ADR_W-1:0]    wr_adr;
  logic [ADR_W-1:0]    rd_adr;
  logic                pad_sel;
  logic [12:0]         col;
  logic [12:0]         row;
  logic                window_valid;
  logic [12:0]         center_col;
  logic [12:0]         center_row;
  logic                frame_done;
  logic                sof_err;

  modport master (
    output pix_valid, pix_sof,
    input  pix_ready, shift_en, row_shift_en, wr_adr, rd_adr, pad_sel, col, row,
           window_valid, center_col, center_row, frame_done, sof_err
  );

  modport slave (
    input  pix_valid, pix_sof,
    output pix_ready, shift_en, row_shift_en, wr_adr, rd_adr, pad_sel, col, row,
           window_valid, center_col, center_row, frame_done, sof_err
  );
endinterface

// File: rtl/linebuf_window_sequencer.sv
// Sequences row-RAM addresses/enables and window shifts for a raster stream; outputs 1 cycle after each shift.
// pix_ready drops during flush and done; upstream must hold its pixel (incl. pix_sof) until ready returns.
module linebuf_window_sequencer #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int NUM_ROWS     = 6,
  parameter int ADR_W        = 10,
  parameter int V_DLY        = 5,
  parameter int H_DLY        = 5
) (
  input logic                        clk,
  input logic                        rst,
  linebuf_window_sequencer_if.slave  bus
);
  localparam int FILL_W = $clog2(NUM_ROWS + 1);
  localparam logic [12:0] COL_LAST   = 13'(LINE_WIDTH - 1);
  localparam logic [12:0] ROW_LAST   = 13'(FRAME_HEIGHT - 1);
  localparam logic [12:0] FLUSH_LAST = 13'(FRAME_HEIGHT + V_DLY - 1);
  localparam logic [12:0] FH13       = 13'(FRAME_HEIGHT);
  localparam logic [12:0] VD13       = 13'(V_DLY);
  localparam logic [12:0] HD13       = 13'(H_DLY);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_ROWS);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [12:0]         nxt_col_q, nxt_col_d, nxt_row_q, nxt_row_d;
  logic [FILL_W-1:0]   fill_q, fill_d;

  logic                shift_en_q, shift_en_d;
  logic [NUM_ROWS-1:0] row_shift_en_q, row_shift_en_d;
  logic [ADR_W-1:0]    wr_adr_q, wr_adr_d, rd_adr_q, rd_adr_d;
  logic                pad_sel_q, pad_sel_d;
  logic [12:0]         col_q, col_d, row_q, row_d;
  logic                window_valid_q, window_valid_d;
  logic [12:0]         center_col_q, center_col_d, center_row_q, center_row_d;
  logic                frame_done_q, frame_done_d;
  logic                sof_err_q, sof_err_d;

  logic                pix_ready, accept, do_shift, pad, restart;
  logic [12:0]         e_col, e_row;
  logic [FILL_W-1:0]   e_fill;

  assign pix_ready = (state_q == IDLE) || (state_q == ACTIVE);
  assign accept    = bus.pix_valid & pix_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      nxt_col_q      <= '0;
      nxt_row_q      <= '0;
      fill_q         <= '0;
      shift_en_q     <= 1'b0;
      row_shift_en_q <= '0;
      wr_adr_q       <= '0;
      rd_adr_q       <= '0;
      pad_sel_q      <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      window_valid_q <= 1'b0;
      center_col_q   <= '0;
      center_row_q   <= '0;
      frame_done_q   <= 1'b0;
      sof_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      nxt_col_q      <= nxt_col_d;
      nxt_row_q      <= nxt_row_d;
      fill_q         <= fill_d;
      shift_en_q     <= shift_en_d;
      row_shift_en_q <= row_shift_en_d;
      wr_adr_q       <= wr_adr_d;
      rd_adr_q       <= rd_adr_d;
      pad_sel_q      <= pad_sel_d;
      col_q          <= col_d;
      row_q          <= row_d;
      window_valid_q <= window_valid_d;
      center_col_q   <= center_col_d;
      center_row_q   <= center_row_d;
      frame_done_q   <= frame_done_d;
      sof_err_q      <= sof_err_d;
    end
  end

  // e_* is the pixel shifted this cycle; nxt_* is where the following one lands.
  always_comb begin
    state_d   = state_q;
    nxt_col_d = nxt_col_q;
    nxt_row_d = nxt_row_q;
    fill_d    = fill_q;
    do_shift  = 1'b0;
    pad       = 1'b0;
    restart   = 1'b0;
    e_col     = nxt_col_q;
    e_row     = nxt_row_q;
    e_fill    = fill_q;
    unique case (state_q)
      IDLE: begin
        if (accept && bus.pix_sof) begin
          do_shift = 1'b1;
          e_col    = '0;
          e_row    = '0;
          e_fill   = '0;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          do_shift = 1'b1;
          if (bus.pix_sof) begin
            restart = 1'b1;
            e_col   = '0;
            e_row   = '0;
            e_fill  = '0;
          end
          if (e_col == COL_LAST && e_row == ROW_LAST) state_d = FLUSH;
        end
      end
      FLUSH: begin
        do_shift = 1'b1;
        pad      = 1'b1;
        if (e_col == COL_LAST && e_row == FLUSH_LAST) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        fill_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    if (do_shift) begin
      if (e_col == COL_LAST) begin
        nxt_col_d = '0;
        nxt_row_d = e_row + 13'd1;
        fill_d    = (e_fill == FILL_MAX) ? e_fill : e_fill + 1'b1;
      end else begin
        nxt_col_d = e_col + 13'd1;
        nxt_row_d = e_row;
        fill_d    = e_fill;
      end
    end
  end

  always_comb begin
    shift_en_d     = do_shift;
    pad_sel_d      = pad;
    sof_err_d      = restart;
    frame_done_d   = (state_q == DONE);
    col_d          = col_q;
    row_d          = row_q;
    wr_adr_d       = wr_adr_q;
    rd_adr_d       = rd_adr_q;
    row_shift_en_d = '0;
    window_valid_d = 1'b0;
    center_col_d   = '0;
    center_row_d   = '0;
    if (do_shift) begin
      col_d    = e_col;
      row_d    = e_row;
      wr_adr_d = e_col[ADR_W-1:0];
      rd_adr_d = (e_col == COL_LAST) ? '0 : ADR_W'(e_col + 13'd1);
      // RAM k only takes a line once RAM k-1 already holds a complete one.
      for (int k = 0; k < NUM_ROWS; k++) row_shift_en_d[k] = (32'(e_fill) >= k);
      window_valid_d = (e_row >= VD13) && (e_col >= HD13) && ((e_row - VD13) < FH13);
      if (window_valid_d) begin
        center_col_d = e_col - HD13;
        center_row_d = e_row - VD13;
      end
    end
  end

  assign bus.pix_ready    = pix_ready;
  assign bus.shift_en     = shift_en_q;
  assign bus.row_shift_en = row_shift_en_q;
  assign bus.wr_adr       = wr_adr_q;
  assign bus.rd_adr       = rd_adr_q;
  assign bus.pad_sel      = pad_sel_q;
  assign bus.col          = col_q;
  assign bus.row          = row_q;
  assign bus.window_valid = window_valid_q;
  assign bus.center_col   = center_col_q;
  assign bus.center_row   = center_row_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.sof_err      = sof_err_q;
endmodule

// File: tb/tb_linebuf_window_sequencer.sv
// Directed bench for the line-buffer window sequencer with an 8x4 frame, 3 rows, 2/2 delays.
module tb_linebuf_window_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  linebuf_window_sequencer_if #(.NUM_ROWS(3), .ADR_W(3)) bus ();

  linebuf_window_sequencer #(
    .LINE_WIDTH(8), .FRAME_HEIGHT(4), .NUM_ROWS(3), .ADR_W(3), .V_DLY(2), .H_DLY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       ready, shift, pad, wv, fdone, serr;
    logic [2:0] rse, wr, rd;
    int         col, row, ccol, crow;
  } exp_t;

  typedef struct {
    logic r, v, sof;
    exp_t e;
  } vec_t;

  int checks = 0;
  int passes = 0;

  task automatic chk(string name, logic [31:0] act, int expv);
    checks++;
    if (act === 32'(expv)) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  function automatic logic [2:0] rse_for(int r);
    return (r == 0) ? 3'b001 : (r == 1) ? 3'b011 : 3'b111;
  endfunction

  function automatic exp_t hold_e(int c, int r);
    exp_t e;
    e.ready = 1'b1; e.shift = 1'b0; e.pad = 1'b0; e.wv = 1'b0; e.fdone = 1'b0; e.serr = 1'b0;
    e.rse = 3'b000; e.wr = 3'(c); e.rd = (c == 7) ? 3'd0 : 3'(c + 1);
    e.col = c; e.row = r; e.ccol = 0; e.crow = 0;
    return e;
  endfunction

  function automatic exp_t pix_e(int c, int r, logic pad, logic ready);
    exp_t e;
    e = hold_e(c, r);
    e.ready = ready; e.shift = 1'b1; e.pad = pad; e.rse = rse_for(r);
    e.wv   = (r >= 2) && (c >= 2) && (r - 2 < 4);
    e.ccol = e.wv ? c - 2 : 0;
    e.crow = e.wv ? r - 2 : 0;
    return e;
  endfunction

  function automatic vec_t mk_vec(logic r, logic v, logic s, exp_t e);
    vec_t t;
    t.r = r; t.v = v; t.sof = s; t.e = e;
    return t;
  endfunction

  task automatic step(logic r, logic v, logic s);
    rst = r; bus.pix_valid = v; bus.pix_sof = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(string tag, exp_t e);
    chk({tag, ".pix_ready"},    32'(bus.pix_ready),    int'(e.ready));
    chk({tag, ".shift_en"},     32'(bus.shift_en),     int'(e.shift));
    chk({tag, ".row_shift_en"}, 32'(bus.row_shift_en), int'(e.rse));
    chk({tag, ".wr_adr"},       32'(bus.wr_adr),       int'(e.wr));
    chk({tag, ".rd_adr"},       32'(bus.rd_adr),       int'(e.rd));
    chk({tag, ".pad_sel"},      32'(bus.pad_sel),      int'(e.pad));
    chk({tag, ".col"},          32'(bus.col),          e.col);
    chk({tag, ".row"},          32'(bus.row),          e.row);
    chk({tag, ".window_valid"}, 32'(bus.window_valid), int'(e.wv));
    chk({tag, ".center_col"},   32'(bus.center_col),   e.ccol);
    chk({tag, ".center_row"},   32'(bus.center_row),   e.crow);
    chk({tag, ".frame_done"},   32'(bus.frame_done),   int'(e.fdone));
    chk({tag, ".sof_err"},      32'(bus.sof_err),      int'(e.serr));
  endtask

  vec_t tbl [9];

  initial begin
    exp_t z, e;
    int   last, wraps, prev_row, pulses;
    z = hold_e(0, 0);
    z.rd = 3'd0;

    // Reset, IDLE drops without sof, frame start, a stall, resume.
    tbl[0] = mk_vec(1'b1, 1'b0, 1'b0, z);
    tbl[1] = mk_vec(1'b1, 1'b1, 1'b1, z);
    tbl[2] = mk_vec(1'b0, 1'b1, 1'b0, z);
    tbl[3] = mk_vec(1'b0, 1'b1, 1'b0, z);
    tbl[4] = mk_vec(1'b0, 1'b0, 1'b0, z);
    tbl[5] = mk_vec(1'b0, 1'b1, 1'b1, pix_e(0, 0, 1'b0, 1'b1));
    tbl[6] = mk_vec(1'b0, 1'b1, 1'b0, pix_e(1, 0, 1'b0, 1'b1));
    tbl[7] = mk_vec(1'b0, 1'b0, 1'b0, hold_e(1, 0));
    tbl[8] = mk_vec(1'b0, 1'b1, 1'b0, pix_e(2, 0, 1'b0, 1'b1));
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].sof);
      check_out($sformatf("vec%0d", i), tbl[i].e);
    end

    // Rest of the clean frame; ready drops once (7,3) is taken.
    for (int p = 3; p < 32; p++) begin
      step(1'b0, 1'b1, 1'b0);
      check_out($sformatf("frame_p%0d", p), pix_e(p % 8, p / 8, 1'b0, p != 31));
    end

    // Flush: upstream presses valid+sof, which must be ignored.
    for (int f = 0; f < 16; f++) begin
      step(1'b0, 1'b1, 1'b1);
      check_out($sformatf("flush_f%0d", f), pix_e(f % 8, 4 + f / 8, 1'b1, 1'b0));
    end
    step(1'b0, 1'b1, 1'b1);
    e = hold_e(7, 5);
    e.fdone = 1'b1;
    check_out("done", e);
    step(1'b0, 1'b0, 1'b0);
    check_out("after_done", hold_e(7, 5));

    // Mid-frame sof at (3,1) restarts the frame.
    step(1'b0, 1'b1, 1'b1);
    check_out("f2_p0", pix_e(0, 0, 1'b0, 1'b1));
    for (int p = 1; p < 11; p++) begin
      step(1'b0, 1'b1, 1'b0);
      check_out($sformatf("f2_p%0d", p), pix_e(p % 8, p / 8, 1'b0, 1'b1));
    end
    step(1'b0, 1'b1, 1'b1);
    e = pix_e(0, 0, 1'b0, 1'b1);
    e.serr = 1'b1;
    check_out("sof_restart", e);
    step(1'b0, 1'b1, 1'b0);
    check_out("restart_p1", pix_e(1, 0, 1'b0, 1'b1));

    // Alternating valid across the line wrap.
    last = 1; prev_row = 0; wraps = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        step(1'b0, 1'b1, 1'b0);
        last++;
        e = pix_e(last % 8, last / 8, 1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b0, 1'b0);
        e = hold_e(last % 8, last / 8);
      end
      check_out($sformatf("toggle%0d", i), e);
      if (bus.shift_en && int'(bus.row) != prev_row) wraps++;
      prev_row = int'(bus.row);
    end
    chk("wrap_count", 32'(wraps), 1);

    for (int p = last + 1; p < 32; p++) begin
      step(1'b0, 1'b1, 1'b0);
      check_out($sformatf("f2_tail%0d", p), pix_e(p % 8, p / 8, 1'b0, p != 31));
    end
    for (int f = 0; f < 5; f++) begin
      step(1'b0, 1'b0, 1'b0);
      check_out($sformatf("f2_flush%0d", f), pix_e(f, 4, 1'b1, 1'b0));
    end

    // Reset mid-flush.
    step(1'b1, 1'b0, 1'b0);
    check_out("rst_mid_flush", z);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.frame_done || bus.shift_en || !bus.pix_ready) pulses++;
    end
    chk("idle_after_rst_activity", 32'(pulses), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
